// File: rtl/irrigation_countdown_timer.sv
// -----------------------------------------------------------------------------
// irrigation_countdown_timer
// Loadable down-counter that times one watering cycle. A start pulse loads
// the duration, valve_on is held while the cycle runs or is paused, and every
// PRESCALE accepted tick_en strobes remove one unit from count. A one-cycle
// done pulse marks natural completion. Edge priority: abort > start > pause >
// tick_en.
//
// Optional feature macro: IRRIGATION_TIMER_AUTO_RELOAD_EN
//   When defined, the duration accepted with start is stored, and each
//   completion reloads it while staying in RUN (done still pulses), until abort.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   start     in   load duration and begin a cycle (pulse)
//   duration  in   cycle length in decrements, sampled with start
//   tick_en   in   timebase strobe, one clk wide
//   pause     in   level, freezes timing while high
//   abort     in   pulse, terminates the cycle at once
//   count     out  remaining decrements
//   valve_on  out  high while RUN or PAUSE
//   busy      out  high while RUN or PAUSE
//   done      out  one-cycle pulse on natural completion
//   state     out  IDLE=00, RUN=01, PAUSE=10, DONE=11
// -----------------------------------------------------------------------------
module irrigation_countdown_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] duration,
  input  logic             tick_en,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             valve_on,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_presc;
  logic             r_valve;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic [PW-1:0]    w_presc_nxt;
  logic             w_done_nxt;
  logic             w_active_nxt;

`ifdef IRRIGATION_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_nxt;
`endif

  // Next-state, next-count and next-prescaler decode for every state.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_presc_nxt = r_presc;
    w_done_nxt  = 1'b0;
`ifdef IRRIGATION_TIMER_AUTO_RELOAD_EN
    w_reload_nxt = r_reload;
`endif
    case (r_state)
      // DONE accepts a new start exactly like IDLE does.
      S_IDLE, S_DONE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = {WIDTH{1'b0}};
          w_presc_nxt = {PW{1'b0}};
        end else if (start) begin
          w_presc_nxt = {PW{1'b0}};
`ifdef IRRIGATION_TIMER_AUTO_RELOAD_EN
          w_reload_nxt = duration;
`endif
          if (duration != {WIDTH{1'b0}}) begin
            w_state_nxt = S_RUN;
            w_count_nxt = duration;
          end else begin
            // Zero-length cycle completes at once; the valve never opens.
            w_state_nxt = S_DONE;
            w_count_nxt = {WIDTH{1'b0}};
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = {WIDTH{1'b0}};
          w_presc_nxt = {PW{1'b0}};
        end else if (pause) begin
          // A tick arriving with pause is dropped.
          w_state_nxt = S_PAUSE;
        end else if (tick_en) begin
          if (r_presc == PRESC_LAST) begin
            w_presc_nxt = {PW{1'b0}};
            // <= 1 also guards against an underflow from a zero count.
            if (r_count <= WIDTH'(1)) begin
              w_done_nxt = 1'b1;
`ifdef IRRIGATION_TIMER_AUTO_RELOAD_EN
              if (r_reload != {WIDTH{1'b0}}) begin
                w_state_nxt = S_RUN;
                w_count_nxt = r_reload;
              end else begin
                w_state_nxt = S_DONE;
                w_count_nxt = {WIDTH{1'b0}};
              end
`else
              w_state_nxt = S_DONE;
              w_count_nxt = {WIDTH{1'b0}};
`endif
            end else begin
              w_count_nxt = r_count - WIDTH'(1);
            end
          end else begin
            w_presc_nxt = r_presc + PW'(1);
          end
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_PAUSE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = {WIDTH{1'b0}};
          w_presc_nxt = {PW{1'b0}};
        end else if (!pause) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_PAUSE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = {WIDTH{1'b0}};
        w_presc_nxt = {PW{1'b0}};
      end
    endcase
    w_active_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE);
  end

  // State and output registers; reset closes the valve without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= {WIDTH{1'b0}};
      r_presc <= {PW{1'b0}};
      r_valve <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_presc <= w_presc_nxt;
      r_valve <= w_active_nxt;
      r_busy  <= w_active_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef IRRIGATION_TIMER_AUTO_RELOAD_EN
  // Stored duration used for reloading at each completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reload <= {WIDTH{1'b0}};
    end else begin
      r_reload <= w_reload_nxt;
    end
  end
`endif

  assign count    = r_count;
  assign valve_on = r_valve;
  assign busy     = r_busy;
  assign done     = r_done;
  assign state    = r_state;

endmodule
